// File: rtl/canvas_mem_ctrl_pkg.sv
// Shared constants, clear-FSM state type and pixel-to-cell helpers for the canvas memory controller.
package canvas_pkg;

    localparam int CELL_SHIFT = 5;
    localparam int COLS       = 20;
    localparam int ROWS       = 15;
    localparam int AW         = 9;
    localparam int CELLS      = COLS * ROWS;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    // Linear cell index; out-of-grid coordinates simply wrap into AW bits.
    function automatic logic [AW-1:0] cell_addr(input logic [9:0] x, input logic [9:0] y);
        logic [9:0]  col;
        logic [9:0]  row;
        logic [15:0] lin;
        col = x >> CELL_SHIFT;
        row = y >> CELL_SHIFT;
        lin = 16'(row) * 16'(COLS) + 16'(col);
        return lin[AW-1:0];
    endfunction

    function automatic logic cell_in_range(input logic [9:0] x, input logic [9:0] y);
        return (int'(x >> CELL_SHIFT) < COLS) && (int'(y >> CELL_SHIFT) < ROWS);
    endfunction

endpackage

// File: rtl/canvas_mem_ctrl_if.sv
// Display, paint and clear signals shared between the VGA/mouse side and the canvas controller.
interface canvas_mem_ctrl_if;
    logic       valid;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       mem_pixel;
    logic       paint_req;
    logic       paint_val;
    logic [9:0] paint_x;
    logic [9:0] paint_y;
    logic       paint_ready;
    logic       paint_done;
    logic       paint_err;
    logic       clear_req;
    logic       clear_busy;
    logic       clear_done;

    modport master (
        output valid, h_cnt, v_cnt, paint_req, paint_val, paint_x, paint_y, clear_req,
        input  mem_pixel, paint_ready, paint_done, paint_err, clear_busy, clear_done
    );

    modport slave (
        input  valid, h_cnt, v_cnt, paint_req, paint_val, paint_x, paint_y, clear_req,
        output mem_pixel, paint_ready, paint_done, paint_err, clear_busy, clear_done
    );
endinterface

// File: rtl/canvas_mem_ctrl_cell_ram.sv
// Single-port 1-bit cell RAM with synchronous read; contents are never reset.
module cell_ram
    import canvas_pkg::*;
(
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wdata_i,
    output logic          rdata_o
);

    logic mem_q [CELLS];
    logic rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/canvas_mem_ctrl.sv
// Canvas cell-memory controller: arbitrates one RAM port between display reads, paint writes and a clear sweep.
//
// state     | meaning
// CLR_IDLE  | no sweep; clear_req starts one at cell 0
// CLR_SWEEP | zeroing cells, advancing only on cycles the port is granted
// CLR_DONE  | one-cycle clear_done pulse, then back to idle
module canvas_mem_ctrl
    import canvas_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    canvas_mem_ctrl_if.slave   bus_if
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic          pend_val_q, pend_val_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          valid_q;

    logic          ram_we;
    logic          ram_wdata;
    logic          ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [AW-1:0] disp_addr;
    logic          paint_ready;
    logic          capture;
    logic          grant_paint;
    logic          grant_sweep;

    assign disp_addr   = cell_addr(bus_if.h_cnt, bus_if.v_cnt);
    assign paint_ready = !pend_q && (state_q != CLR_SWEEP);
    assign capture     = bus_if.paint_req && paint_ready;
    assign grant_paint = !bus_if.valid && pend_q;
    assign grant_sweep = !bus_if.valid && !pend_q && (state_q == CLR_SWEEP);

    // Writes are suppressed during reset so an aborted sweep leaves the current cell untouched.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = disp_addr;
        ram_wdata = 1'b0;
        if (grant_paint) begin
            ram_we    = !rst;
            ram_addr  = pend_addr_q;
            ram_wdata = pend_val_q;
        end else if (grant_sweep) begin
            ram_we    = !rst;
            ram_addr  = clr_addr_q;
        end
    end

    always_comb begin
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_val_d  = pend_val_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        if (grant_paint) begin
            pend_d = 1'b0;
            done_d = 1'b1;
        end
        if (capture) begin
            if (cell_in_range(bus_if.paint_x, bus_if.paint_y)) begin
                pend_d      = 1'b1;
                pend_addr_d = cell_addr(bus_if.paint_x, bus_if.paint_y);
                pend_val_d  = bus_if.paint_val;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLR_IDLE: begin
                if (bus_if.clear_req) begin
                    state_d    = CLR_SWEEP;
                    clr_addr_d = '0;
                end
            end
            CLR_SWEEP: begin
                if (grant_sweep) begin
                    clr_addr_d = clr_addr_q + 1'b1;
                    if (clr_addr_q == AW'(CELLS - 1)) begin
                        state_d = CLR_DONE;
                    end
                end
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLR_IDLE;
            clr_addr_q  <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_val_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_val_q  <= pend_val_d;
            done_q      <= done_d;
            err_q       <= err_d;
            valid_q     <= bus_if.valid;
        end
    end

    cell_ram u_cell_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus_if.mem_pixel   = valid_q & ram_rdata;
    assign bus_if.paint_ready = paint_ready;
    assign bus_if.paint_done  = done_q;
    assign bus_if.paint_err   = err_q;
    assign bus_if.clear_busy  = (state_q == CLR_SWEEP);
    assign bus_if.clear_done  = (state_q == CLR_DONE);

endmodule

// File: tb/tb_canvas_mem_ctrl.sv
// Self-checking bench for canvas_mem_ctrl against a cell-array model of the 20x15 grid.
module tb_canvas_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   model [300];

    canvas_mem_ctrl_if bus_if ();

    canvas_mem_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.valid     = 1'b0;
        bus_if.h_cnt     = '0;
        bus_if.v_cnt     = '0;
        bus_if.paint_req = 1'b0;
        bus_if.paint_val = 1'b0;
        bus_if.paint_x   = '0;
        bus_if.paint_y   = '0;
        bus_if.clear_req = 1'b0;
    endtask

    function automatic logic [5:0] outs();
        return {bus_if.mem_pixel, bus_if.paint_ready, bus_if.paint_done,
                bus_if.paint_err, bus_if.clear_busy, bus_if.clear_done};
    endfunction

    // Random pixel inside cell c.
    task automatic pix_of(input int c, output logic [9:0] x, output logic [9:0] y);
        x = 10'((c % 20) * 32 + int'($urandom_range(31, 0)));
        y = 10'((c / 20) * 32 + int'($urandom_range(31, 0)));
    endtask

    // Paint during blanking; returns {ready,err,done} one cycle and two cycles after the request.
    task automatic paint_blank(input logic [9:0] x, input logic [9:0] y, input logic v,
                               output logic [5:0] obs);
        bus_if.valid     = 1'b0;
        bus_if.paint_x   = x;
        bus_if.paint_y   = y;
        bus_if.paint_val = v;
        bus_if.paint_req = 1'b1;
        step();
        bus_if.paint_req = 1'b0;
        obs[5:3] = {bus_if.paint_ready, bus_if.paint_err, bus_if.paint_done};
        step();
        obs[2:0] = {bus_if.paint_ready, bus_if.paint_err, bus_if.paint_done};
    endtask

    task automatic paint_all(input logic v, output int dones);
        logic [9:0] x, y;
        logic [5:0] obs;
        dones = 0;
        for (int c = 0; c < 300; c++) begin
            pix_of(c, x, y);
            paint_blank(x, y, v, obs);
            if (obs == 6'b000_101) dones++;
            model[c] = v;
        end
    endtask

    task automatic test_scan(input int lo, input int hi);
        logic [9:0] x, y;
        for (int c = lo; c < hi; c++) begin
            pix_of(c, x, y);
            bus_if.valid = 1'b1;
            bus_if.h_cnt = x;
            bus_if.v_cnt = y;
            step();
            checks++;
            if (bus_if.mem_pixel !== model[c]) begin
                errors++;
                $display("FAIL scan cell %0d got %0b exp %0b", c, bus_if.mem_pixel, model[c]);
            end
        end
        bus_if.valid = 1'b0;
        step();
        checks++;
        if (bus_if.mem_pixel !== 1'b0) begin
            errors++;
            $display("FAIL blank_pixel got %0b exp 0", bus_if.mem_pixel);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        checks++;
        if (outs() !== 6'b010000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 010000", outs());
        end
        rst = 1'b0;
        step();
        checks++;
        if (outs() !== 6'b010000) begin
            errors++;
            $display("FAIL after_reset_outputs got %b exp 010000", outs());
        end
    endtask

    task automatic test_clear_all();
        int dones, busy_cnt, done_at, ready_bad;
        paint_all(1'b1, dones);
        checks++;
        if (dones != 300) begin
            errors++;
            $display("FAIL preload_dones got %0d exp 300", dones);
        end
        idle_inputs();
        bus_if.clear_req = 1'b1;
        step();
        bus_if.clear_req = 1'b0;
        busy_cnt = 0;
        done_at = -1;
        ready_bad = 0;
        for (int k = 0; k < 400; k++) begin
            if (bus_if.clear_busy) busy_cnt++;
            if (bus_if.clear_busy && bus_if.paint_ready) ready_bad++;
            if (bus_if.clear_done && done_at < 0) done_at = k;
            bus_if.clear_req = (k == 100);
            step();
        end
        checks++;
        if (busy_cnt != 300) begin
            errors++;
            $display("FAIL clear_busy_cycles got %0d exp 300", busy_cnt);
        end
        checks++;
        if (done_at != 300) begin
            errors++;
            $display("FAIL clear_done_cycle got %0d exp 300", done_at);
        end
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL ready_during_sweep got %0d exp 0", ready_bad);
        end
        for (int c = 0; c < 300; c++) model[c] = 1'b0;
        test_scan(0, 300);
    endtask

    task automatic test_paint_blank();
        logic [5:0] obs;
        paint_blank(10'd70, 10'd40, 1'b1, obs);
        checks++;
        if (obs !== 6'b000_101) begin
            errors++;
            $display("FAIL paint_blank_handshake got %b exp 000101", obs);
        end
        model[22] = 1'b1;
        step();
        checks++;
        if (bus_if.paint_done !== 1'b0) begin
            errors++;
            $display("FAIL paint_done_single got %0b exp 0", bus_if.paint_done);
        end
        for (int h = 64; h < 96; h++) begin
            bus_if.valid = 1'b1;
            bus_if.h_cnt = 10'(h);
            bus_if.v_cnt = 10'd32;
            step();
            checks++;
            if (bus_if.mem_pixel !== model[20 + h / 32]) begin
                errors++;
                $display("FAIL paint_scan h=%0d got %0b exp %0b", h, bus_if.mem_pixel, model[20 + h / 32]);
            end
        end
        bus_if.valid = 1'b0;
        step();
    endtask

    task automatic test_paint_active();
        logic [9:0] x, y;
        int c;
        for (int k = 0; k < 100; k++) begin
            c = int'($urandom_range(299, 0));
            pix_of(c, x, y);
            bus_if.valid     = 1'b1;
            bus_if.h_cnt     = x;
            bus_if.v_cnt     = y;
            bus_if.paint_req = (k == 5);
            bus_if.paint_x   = '0;
            bus_if.paint_y   = '0;
            bus_if.paint_val = 1'b1;
            step();
            checks++;
            if (bus_if.mem_pixel !== model[c]) begin
                errors++;
                $display("FAIL active_pixel k=%0d cell %0d got %0b exp %0b", k, c, bus_if.mem_pixel, model[c]);
            end
            if (k >= 5) begin
                checks++;
                if ({bus_if.paint_ready, bus_if.paint_done} !== 2'b00) begin
                    errors++;
                    $display("FAIL active_pending k=%0d got %b exp 00", k, {bus_if.paint_ready, bus_if.paint_done});
                end
            end
        end
        bus_if.paint_req = 1'b0;
        bus_if.valid = 1'b0;
        step();
        checks++;
        if ({bus_if.paint_ready, bus_if.paint_done} !== 2'b11) begin
            errors++;
            $display("FAIL active_commit got %b exp 11", {bus_if.paint_ready, bus_if.paint_done});
        end
        model[0] = 1'b1;
        test_scan(0, 20);
    endtask

    task automatic check_paint(input logic [9:0] x, input logic [9:0] y, input logic v, input string tag);
        logic [5:0] obs, exp_obs;
        int col, row;
        col = int'(x) / 32;
        row = int'(y) / 32;
        paint_blank(x, y, v, obs);
        if (col < 20 && row < 15) begin
            exp_obs = 6'b000_101;
            model[row * 20 + col] = v;
        end else begin
            exp_obs = 6'b110_100;
        end
        checks++;
        if (obs !== exp_obs) begin
            errors++;
            $display("FAIL %s x=%0d y=%0d got %b exp %b", tag, x, y, obs, exp_obs);
        end
    endtask

    task automatic test_out_of_range();
        check_paint(10'd650, 10'd10, 1'b1, "oor_x");
        check_paint(10'd100, 10'd480, 1'b1, "oor_y");
        check_paint(10'd1023, 10'd1023, 1'b1, "oor_max");
        check_paint(10'd639, 10'd479, 1'b1, "edge_cell");
        check_paint(10'd640, 10'd479, 1'b1, "edge_col");
        test_scan(0, 300);
    endtask

    task automatic test_random_paint();
        for (int i = 0; i < 40; i++) begin
            check_paint(10'($urandom_range(700, 0)), 10'($urandom_range(540, 0)),
                        1'($urandom_range(1, 0)), "rand_paint");
        end
        test_scan(0, 300);
    endtask

    task automatic test_paint_and_clear();
        logic [9:0] x, y;
        int done_at;
        pix_of(int'($urandom_range(299, 0)), x, y);
        idle_inputs();
        bus_if.paint_x   = x;
        bus_if.paint_y   = y;
        bus_if.paint_val = 1'b1;
        bus_if.paint_req = 1'b1;
        bus_if.clear_req = 1'b1;
        step();
        idle_inputs();
        checks++;
        if ({bus_if.paint_ready, bus_if.clear_busy} !== 2'b01) begin
            errors++;
            $display("FAIL simul_accept got %b exp 01", {bus_if.paint_ready, bus_if.clear_busy});
        end
        step();
        checks++;
        if ({bus_if.paint_done, bus_if.clear_busy} !== 2'b11) begin
            errors++;
            $display("FAIL simul_paint_first got %b exp 11", {bus_if.paint_done, bus_if.clear_busy});
        end
        done_at = -1;
        for (int k = 2; k < 400 && done_at < 0; k++) begin
            step();
            if (bus_if.clear_done) done_at = k;
        end
        checks++;
        if (done_at != 301) begin
            errors++;
            $display("FAIL simul_clear_done got %0d exp 301", done_at);
        end
        for (int c = 0; c < 300; c++) model[c] = 1'b0;
        test_scan(0, 300);
    endtask

    task automatic test_clear_interleaved();
        logic [9:0] x, y;
        int dones, wr, done_at, c;
        bit v, sweeping;
        logic [1:0] exp_st;
        paint_all(1'b1, dones);
        checks++;
        if (dones != 300) begin
            errors++;
            $display("FAIL preload2_dones got %0d exp 300", dones);
        end
        idle_inputs();
        bus_if.clear_req = 1'b1;
        step();
        bus_if.clear_req = 1'b0;
        wr = 0;
        done_at = -1;
        c = 0;
        for (int k = 1; k < 4000 && done_at < 0; k++) begin
            v = ((k - 1) % 200) < 160;
            bus_if.valid = v;
            if (v) begin
                c = int'($urandom_range(299, 0));
                pix_of(c, x, y);
                bus_if.h_cnt = x;
                bus_if.v_cnt = y;
            end
            sweeping = (wr < 300);
            step();
            if (!v && sweeping) begin
                model[wr] = 1'b0;
                wr++;
            end
            exp_st = {wr < 300, sweeping && wr == 300};
            checks++;
            if ({bus_if.clear_busy, bus_if.clear_done} !== exp_st) begin
                errors++;
                $display("FAIL interleave_state k=%0d got %b exp %b", k, {bus_if.clear_busy, bus_if.clear_done}, exp_st);
            end
            if (v) begin
                checks++;
                if (bus_if.mem_pixel !== model[c]) begin
                    errors++;
                    $display("FAIL interleave_pixel k=%0d cell %0d got %0b exp %0b", k, c, bus_if.mem_pixel, model[c]);
                end
            end
            if (bus_if.clear_done) done_at = k;
        end
        checks++;
        if (done_at < 0) begin
            errors++;
            $display("FAIL interleave_timeout got no clear_done exp clear_done");
        end
        bus_if.valid = 1'b0;
        test_scan(0, 300);
    endtask

    task automatic test_reset_mid_sweep();
        int dones, early_done;
        paint_all(1'b1, dones);
        idle_inputs();
        bus_if.clear_req = 1'b1;
        step();
        bus_if.clear_req = 1'b0;
        early_done = 0;
        for (int k = 1; k <= 150; k++) begin
            step();
            if (bus_if.clear_done) early_done++;
        end
        rst = 1'b1;
        step();
        checks++;
        if (outs() !== 6'b010000) begin
            errors++;
            $display("FAIL mid_sweep_reset got %b exp 010000", outs());
        end
        rst = 1'b0;
        step();
        if (bus_if.clear_done || bus_if.clear_busy) early_done++;
        checks++;
        if (early_done != 0) begin
            errors++;
            $display("FAIL mid_sweep_no_done got %0d exp 0", early_done);
        end
        for (int c = 0; c < 150; c++) model[c] = 1'b0;
        test_scan(0, 300);
    endtask

    task automatic test_reset_pending();
        logic [9:0] x, y;
        int c, seen;
        c = int'($urandom_range(299, 0));
        pix_of(c, x, y);
        idle_inputs();
        bus_if.valid     = 1'b1;
        bus_if.paint_x   = x;
        bus_if.paint_y   = y;
        bus_if.paint_val = ~model[c];
        bus_if.paint_req = 1'b1;
        step();
        bus_if.paint_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_if.valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus_if.paint_done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL pending_dropped got %0d exp 0", seen);
        end
        test_scan(c, c + 1);
    endtask

    initial begin
        test_reset();
        test_clear_all();
        test_paint_blank();
        test_paint_active();
        test_out_of_range();
        test_random_paint();
        test_paint_and_clear();
        test_clear_interleaved();
        test_reset_mid_sweep();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
